// File: rtl/bit_serializer_pkg.sv
// bit_serializer_pkg: state encoding and width helper shared by the serializer and the detector bench
package bit_serializer_pkg;
  typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction
endpackage

// File: rtl/bit_serializer.sv
// bit_serializer: valid/ready parallel-in, one-bit-per-clock serial-out feeder for the 1101 detector
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             word_done,
  output logic             busy
);
  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic last, accept;
  assign last       = (state == S_SHIFT) && (cnt == LAST);
  assign din_ready  = (state == S_IDLE) || last;
  assign accept     = din_valid && din_ready;
  assign busy       = (state == S_SHIFT);
  assign sout_valid = busy;
  assign word_done  = last;
  // idle forces 0 so the detector never sees stale shift-register bits
  assign sout = busy & (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    if (accept) begin
      state_nxt = S_SHIFT;
      shreg_nxt = din;
      cnt_nxt   = '0;
    end else if (last) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end else if (state == S_SHIFT) begin
      shreg_nxt = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
      cnt_nxt   = cnt + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      cnt   <= cnt_nxt;
    end
  end
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: scoreboard bench for bit_serializer in MSB-first and LSB-first builds
module tb_bit_serializer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] din = '0, din_l = '0;
  logic din_valid = 1'b0, din_valid_l = 1'b0;
  logic din_ready, sout, sout_valid, word_done, busy;
  logic din_ready_l, sout_l, sout_valid_l, word_done_l, busy_l;
  bit q[$];
  bit q_l[$];
  bit e;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .sout(sout), .sout_valid(sout_valid), .word_done(word_done), .busy(busy)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .din(din_l), .din_valid(din_valid_l), .din_ready(din_ready_l),
    .sout(sout_l), .sout_valid(sout_valid_l), .word_done(word_done_l), .busy(busy_l)
  );

  task automatic push_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) q.push_back(w[i]);
  endtask

  task automatic test_reset;
    din = 8'hFF; din_valid = 1'b1; din_l = 8'hFF; din_valid_l = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({sout, sout_valid, busy, word_done, din_ready} !== 5'b00001) begin
        errors++; $display("FAIL reset c%0d: {sout,valid,busy,done,ready}=%b want 00001", c, {sout, sout_valid, busy, word_done, din_ready});
      end
      checks++;
      if ({sout_l, sout_valid_l, din_ready_l} !== 3'b001) begin
        errors++; $display("FAIL reset_lsb c%0d: {sout,valid,ready}=%b want 001", c, {sout_l, sout_valid_l, din_ready_l});
      end
    end
    din_valid = 1'b0; din_valid_l = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (sout_valid !== 1'b0 || din_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release: valid=%b ready=%b want 0 1", sout_valid, din_ready);
    end
  endtask

  task automatic test_single;
    din = 8'hD0; din_valid = 1'b1; push_word(8'hD0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) din_valid = 1'b0;
      e = q.pop_front();
      checks++;
      if (sout !== e || sout_valid !== 1'b1 || word_done !== (i == 8)) begin
        errors++; $display("FAIL single c%0d: sout=%b valid=%b done=%b want %b 1 %b", i, sout, sout_valid, word_done, e, i == 8);
      end
    end
    @(negedge clk);
    checks++;
    if ({sout, sout_valid, busy, din_ready} !== 4'b0001) begin
      errors++; $display("FAIL single_idle: {sout,valid,busy,ready}=%b want 0001", {sout, sout_valid, busy, din_ready});
    end
  endtask

  task automatic test_back_to_back;
    din = 8'hDD; din_valid = 1'b1; push_word(8'hDD);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 1) din = 8'h0D;
      if (i == 9) din_valid = 1'b0;
      e = q.pop_front();
      checks++;
      if (sout !== e || sout_valid !== 1'b1 || word_done !== (i == 8 || i == 16) || din_ready !== (i == 8 || i == 16)) begin
        errors++; $display("FAIL b2b c%0d: sout=%b valid=%b done=%b ready=%b want %b 1 %b %b", i, sout, sout_valid, word_done, din_ready, e, i == 8 || i == 16, i == 8 || i == 16);
      end
      if (i == 8) push_word(8'h0D);
    end
    @(negedge clk);
    checks++;
    if (sout_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: valid=%b want 0", sout_valid);
    end
  endtask

  task automatic test_midword_request;
    din = 8'hFF; din_valid = 1'b1; push_word(8'hFF);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 1) din_valid = 1'b0;
      if (i == 9) din_valid = 1'b0;
      e = q.pop_front();
      checks++;
      if (sout !== e || sout_valid !== 1'b1 || din_ready !== (i == 8 || i == 16)) begin
        errors++; $display("FAIL midword c%0d: sout=%b valid=%b ready=%b want %b 1 %b", i, sout, sout_valid, din_ready, e, i == 8 || i == 16);
      end
      if (i == 3) begin din = 8'h0D; din_valid = 1'b1; end
      if (i == 8) push_word(8'h0D);
    end
    @(negedge clk);
    checks++;
    if (sout_valid !== 1'b0) begin
      errors++; $display("FAIL midword_idle: valid=%b want 0", sout_valid);
    end
  endtask

  task automatic test_reset_midword;
    din = 8'hB4; din_valid = 1'b1; push_word(8'hB4);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) din_valid = 1'b0;
      e = q.pop_front();
      checks++;
      if (sout !== e || sout_valid !== 1'b1) begin
        errors++; $display("FAIL rstmid c%0d: sout=%b valid=%b want %b 1", i, sout, sout_valid, e);
      end
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({sout, sout_valid, busy, din_ready} !== 4'b0001) begin
      errors++; $display("FAIL rstmid_async: {sout,valid,busy,ready}=%b want 0001", {sout, sout_valid, busy, din_ready});
    end
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({sout_valid, din_ready} !== 2'b01) begin
      errors++; $display("FAIL rstmid_release: valid=%b ready=%b want 0 1", sout_valid, din_ready);
    end
    din = 8'h80; din_valid = 1'b1; push_word(8'h80);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) din_valid = 1'b0;
      e = q.pop_front();
      checks++;
      if (sout !== e || sout_valid !== 1'b1 || word_done !== (i == 8)) begin
        errors++; $display("FAIL rstmid_new c%0d: sout=%b valid=%b done=%b want %b 1 %b", i, sout, sout_valid, word_done, e, i == 8);
      end
    end
  endtask

  task automatic test_lsb_first;
    logic [7:0] w;
    w = 8'h0B;
    din_l = w; din_valid_l = 1'b1;
    for (int i = 0; i < 8; i++) q_l.push_back(w[i]);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) din_valid_l = 1'b0;
      e = q_l.pop_front();
      checks++;
      if (sout_l !== e || sout_valid_l !== 1'b1 || word_done_l !== (i == 8)) begin
        errors++; $display("FAIL lsb c%0d: sout=%b valid=%b done=%b want %b 1 %b", i, sout_l, sout_valid_l, word_done_l, e, i == 8);
      end
    end
    @(negedge clk);
    checks++;
    if ({sout_l, sout_valid_l, busy_l} !== 3'b000) begin
      errors++; $display("FAIL lsb_idle: {sout,valid,busy}=%b want 000", {sout_l, sout_valid_l, busy_l});
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_midword_request;
    test_reset_midword;
    test_lsb_first;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
